fir_chan_arbiter: RTL and testbench
===================================

Name: fir_chan_arbiter

Overview:
Time-multiplexes the single dual-MAC FIR engine between NCH independent ANC channels (e.g. left/right ear controllers).
- Each channel hands over one (x, a) sample pair through a valid/ready handshake.
- The arbiter picks channels round-robin, launches the FIR with a one-cycle go pulse and waits for done.
- The FIR result is routed back to the granted channel.
- Sits between the per-channel controllers and the FIR, replacing their direct fir_go/fir_done wiring.

Parameters:
NCH, 2, number of requesting channels (2..8)
DW, 16, sample width in bits
TIMEOUT, 1023, max cycles in BUSY before the job is abandoned
CW, 10, width of the timeout counter (2^CW > TIMEOUT)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ch_valid  in  NCH  per-channel sample valid
ch_ready  out  NCH  per-channel holding register empty
ch_x  in  NCH*DW  packed signed x samples, channel i at [i*DW +: DW]
ch_a  in  NCH*DW  packed signed a samples
ch_out_sample  out  DW  signed FIR result for the channel flagged in ch_out_valid
ch_out_valid  out  NCH  one-hot, one-cycle result strobe
fir_go  out  1  FIR start pulse
fir_x  out  DW  x to FIR, stable from go until done
fir_a  out  DW  a to FIR, stable from go until done
fir_done  in  1  FIR completion pulse
fir_out  in  DW  FIR result, valid with fir_done
busy  out  1  high when state is not IDLE
err_timeout  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (async, any state): state=IDLE, pend=0, holding regs=0, last_grant=NCH-1, all outputs 0. ch_ready reads all-ones once reset is released.
- Holding per channel:
  - ch_ready[i] = !pend[i].
  - ch_valid[i] & ch_ready[i] at edge T loads the x/a holding regs and sets pend[i] at T+1.
  - Valid while not ready is ignored; the source must hold or drop the sample.
- FSM: IDLE -> ISSUE -> BUSY -> IDLE.
  - IDLE:
    - If pend != 0, choose the first pending channel scanning from last_grant+1 modulo NCH.
    - Register the grant id and copy that channel's holding regs into fir_x/fir_a.
    - Clear pend[grant] and go to ISSUE.
    - A channel whose pend sets in the same cycle is not eligible until the next IDLE cycle.
  - ISSUE: fir_go=1 for exactly this cycle; reset the timeout counter; go to BUSY. fir_done is ignored here.
  - BUSY:
    - fir_done=1: register fir_out into ch_out_sample, pulse ch_out_valid[grant] the next cycle, set last_grant=grant, go to IDLE.
    - Else the counter increments; when it reaches TIMEOUT, set err_timeout, update last_grant, produce no output, go to IDLE.
- Latency:
  - Uncontended sample accepted at edge T: pend at T+1, IDLE grant at T+1, fir_go high in cycle T+2.
  - With fir_done in cycle D, ch_out_valid is high in cycle D+1.
  - Minimum spacing between consecutive fir_go pulses is 3 cycles (BUSY with done, IDLE, ISSUE).
- ch_ready[grant] rises the cycle after the grant, so a channel may reload while its job runs in the FIR.
- fir_done outside BUSY is dropped and causes no error.
- ch_out_sample holds its last value between strobes; ch_out_valid is never multi-hot.
- Fairness: with all channels continuously pending, grants cycle 0,1,..,NCH-1,0 with no starvation.

Optional Feature:
Macro FIR_ARB_STATS_EN.
- Defined: adds output port grant_cnt (NCH*16 bits), one 16-bit saturating counter per channel.
  - Increments on each completed (fir_done) job for that channel; saturates at 0xFFFF.
  - Timeouts do not increment it; reset clears it.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Shared package anc_pkg:
  - FSM state typedef (IDLE, ISSUE, BUSY).
  - DW default; channel-id width constant $clog2(NCH).
  - Stats counter width 16.
- One sub-module, rr_arbiter: combinational round-robin priority pick.
  - Inputs: pend vector and last_grant. Outputs: grant id and any_req.
  - Instantiated once in the IDLE decision path.

Test Plan:
1. Ch0 sends x=0x0100, a=0x0200, FIR model returns 0x1234 after 5 cycles -> fir_go in cycle T+2 with fir_x=0x0100, fir_a=0x0200; ch_out_valid=2'b01 and ch_out_sample=0x1234 one cycle after done.
2. Ch0 and ch1 valid in the same cycle, last_grant=1 after reset -> ch0 served first, then ch1; exactly two fir_go pulses ≥3 cycles apart.
3. Both channels valid every cycle, 8 jobs -> grant order 0,1,0,1,0,1,0,1; no ch_out_valid overlap.
4. FIR model never asserts done -> after 1023 BUSY cycles err_timeout=1 and no ch_out_valid; next pending channel then granted; err_timeout stays 1 until reset.
5. rst_n pulsed low mid-BUSY -> immediately busy=0, fir_go=0, ch_out_valid=0, err_timeout=0; ch_ready=all-ones after release; a late fir_done is ignored.
6. FIR_ARB_STATS_EN defined, 3 completions on ch1 plus one timeout on ch1 -> grant_cnt[31:16]=3 and grant_cnt[15:0]=0.

Source files
------------

// File: rtl/fir_chan_arbiter_pkg.sv
// Shared types and constants for the FIR channel arbiter slice.
package anc_pkg;

  localparam int DW_DEF  = 16;
  localparam int NCH_DEF = 2;
  localparam int CHW_DEF = $clog2(NCH_DEF);
  localparam int STAT_W  = 16;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE  = 2'd0;
  localparam fsm_state_t ST_ISSUE = 2'd1;
  localparam fsm_state_t ST_BUSY  = 2'd2;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fir_chan_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first pending channel after last_grant.
module rr_arbiter #(
  parameter int NCH = 2,
  parameter int CHW = 1
) (
  input  logic [NCH-1:0] pend,
  input  logic [CHW-1:0] last_grant,
  output logic [CHW-1:0] grant,
  output logic           any_req
);

  int             sum;
  logic [CHW-1:0] idx;
  logic           found;

  // Scan upward from last_grant+1, wrapping once around the channel set.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      sum = int'(last_grant) + k;
      if (sum >= NCH) begin
        sum = sum - NCH;
      end else begin
        sum = sum;
      end
      idx = CHW'(sum);
      if (!found && pend[idx]) begin
        found = 1'b1;
        grant = idx;
      end else begin
        found = found;
      end
    end
    any_req = |pend;
  end

endmodule

// File: rtl/fir_chan_arbiter.sv
// Round-robin time-multiplexer of one FIR engine across NCH channels.
// Optional per-channel completion counters: define FIR_ARB_STATS_EN.
module fir_chan_arbiter
  import anc_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 1023,
  parameter int CW      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_valid,
  output logic [NCH-1:0]    ch_ready,
  input  logic [NCH*DW-1:0] ch_x,
  input  logic [NCH*DW-1:0] ch_a,
  output logic [DW-1:0]     ch_out_sample,
  output logic [NCH-1:0]    ch_out_valid,
  output logic              fir_go,
  output logic [DW-1:0]     fir_x,
  output logic [DW-1:0]     fir_a,
  input  logic              fir_done,
  input  logic [DW-1:0]     fir_out,
  output logic              busy,
`ifdef FIR_ARB_STATS_EN
  output logic [NCH*STAT_W-1:0] grant_cnt,
`endif
  output logic              err_timeout
);

  localparam int CHW = $clog2(NCH);

  fsm_state_t             state_q, state_d;
  logic [NCH-1:0]         pend_q, pend_d, ready_q, ready_d, out_valid_q, out_valid_d;
  logic [NCH-1:0][DW-1:0] hold_x_q, hold_x_d, hold_a_q, hold_a_d;
  logic [CHW-1:0]         grant_q, grant_d, last_grant_q, last_grant_d, arb_grant;
  logic [DW-1:0]          fir_x_q, fir_x_d, fir_a_q, fir_a_d, out_sample_q, out_sample_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   fir_go_q, fir_go_d, busy_q, busy_d, err_q, err_d, arb_any;

  rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_rr (
    .pend       (pend_q),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  // Handshake capture plus IDLE/ISSUE/BUSY job sequencing.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    hold_x_d     = hold_x_q;
    hold_a_d     = hold_a_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    fir_x_d      = fir_x_q;
    fir_a_d      = fir_a_q;
    cnt_d        = cnt_q;
    out_sample_d = out_sample_q;
    out_valid_d  = '0;
    err_d        = err_q;
    fir_go_d     = 1'b0;
    cnt_inc      = cnt_q + CW'(1);
    for (int i = 0; i < NCH; i++) begin
      if (ch_valid[i] && ready_q[i]) begin
        pend_d[i]   = 1'b1;
        hold_x_d[i] = ch_x[i*DW +: DW];
        hold_a_d[i] = ch_a[i*DW +: DW];
      end else begin
        pend_d[i] = pend_d[i];
      end
    end
    case (state_q)
      ST_IDLE: begin
        // Arbiter only sees pend_q, so same-cycle arrivals wait one cycle.
        if (arb_any) begin
          grant_d           = arb_grant;
          fir_x_d           = hold_x_q[arb_grant];
          fir_a_d           = hold_a_q[arb_grant];
          pend_d[arb_grant] = 1'b0;
          fir_go_d          = 1'b1;
          state_d           = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (fir_done) begin
          out_sample_d         = fir_out;
          out_valid_d[grant_q] = 1'b1;
          last_grant_d         = grant_q;
          state_d              = ST_IDLE;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          cnt_d        = cnt_inc;
          err_d        = 1'b1;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = ~pend_d;
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      ready_q      <= '0;
      hold_x_q     <= '0;
      hold_a_q     <= '0;
      grant_q      <= '0;
      last_grant_q <= CHW'(NCH - 1);
      fir_x_q      <= '0;
      fir_a_q      <= '0;
      cnt_q        <= '0;
      out_sample_q <= '0;
      out_valid_q  <= '0;
      err_q        <= 1'b0;
      fir_go_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      ready_q      <= ready_d;
      hold_x_q     <= hold_x_d;
      hold_a_q     <= hold_a_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      fir_x_q      <= fir_x_d;
      fir_a_q      <= fir_a_d;
      cnt_q        <= cnt_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      fir_go_q     <= fir_go_d;
      busy_q       <= busy_d;
    end
  end

  assign ch_ready      = ready_q;
  assign ch_out_sample = out_sample_q;
  assign ch_out_valid  = out_valid_q;
  assign fir_go        = fir_go_q;
  assign fir_x         = fir_x_q;
  assign fir_a         = fir_a_q;
  assign busy          = busy_q;
  assign err_timeout   = err_q;

`ifdef FIR_ARB_STATS_EN
  logic [NCH-1:0][STAT_W-1:0] gcnt_q, gcnt_d;

  // Completed-job counters; timeouts leave them untouched.
  always_comb begin
    gcnt_d = gcnt_q;
    if (state_q == ST_BUSY && fir_done) begin
      gcnt_d[grant_q] = sat_inc(gcnt_q[grant_q]);
    end else begin
      gcnt_d = gcnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign grant_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_fir_chan_arbiter.sv
// Directed self-checking bench for fir_chan_arbiter with a behavioural FIR model.
module tb_fir_chan_arbiter;
  localparam int NCH = 2;
  localparam int DW  = 16;

  logic              clk, rst_n;
  logic [NCH-1:0]    ch_valid, ch_ready, ch_out_valid;
  logic [NCH*DW-1:0] ch_x, ch_a;
  logic [DW-1:0]     ch_out_sample, fir_x, fir_a, fir_out;
  logic              fir_go, fir_done, busy, err_timeout;
`ifdef FIR_ARB_STATS_EN
  logic [NCH*16-1:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit model_en    = 1'b1;
  bit model_fixed = 1'b0;
  int model_lat   = 5;
  int model_timer = 0;

  fir_chan_arbiter #(.NCH(NCH), .DW(DW), .TIMEOUT(1023), .CW(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ch_valid      (ch_valid),
    .ch_ready      (ch_ready),
    .ch_x          (ch_x),
    .ch_a          (ch_a),
    .ch_out_sample (ch_out_sample),
    .ch_out_valid  (ch_out_valid),
    .fir_go        (fir_go),
    .fir_x         (fir_x),
    .fir_a         (fir_a),
    .fir_done      (fir_done),
    .fir_out       (fir_out),
    .busy          (busy),
`ifdef FIR_ARB_STATS_EN
    .grant_cnt     (grant_cnt),
`endif
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIR model: done pulse model_lat cycles after go, result x+a (or 0x1234).
  initial begin
    fir_done = 1'b0;
    fir_out  = '0;
    forever begin
      @(posedge clk);
      #2;
      fir_done = 1'b0;
      if (model_timer > 0) begin
        model_timer--;
        if (model_timer == 0) begin
          fir_done = 1'b1;
          fir_out  = model_fixed ? 16'h1234 : fir_x + fir_a;
        end
      end
      if (fir_go && model_en) model_timer = model_lat;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ch_valid = '0;
    model_timer = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send(input int ch, input logic [DW-1:0] x, input logic [DW-1:0] a);
    ch_x[ch*DW +: DW] = x;
    ch_a[ch*DW +: DW] = a;
    ch_valid[ch] = 1'b1;
    step();
    ch_valid[ch] = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (ch_out_valid == '0 && cyc < 2000) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch_valid = '0;
    ch_x = '0;
    ch_a = '0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (fir_go !== 1'b0) begin n_fail++; $display("FAIL reset_go got %b want 0", fir_go); end
    n_checks++; if (ch_out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_outv got %b want 00", ch_out_valid); end
    n_checks++; if (ch_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", ch_ready); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_timeout); end
    n_checks++; if (ch_out_sample !== 16'h0000) begin n_fail++; $display("FAIL reset_sample got %h want 0000", ch_out_sample); end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (ch_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready_rel got %b want 11", ch_ready); end
  endtask

  task automatic test_single();
    int cyc;
    model_fixed = 1'b1;
    model_lat   = 5;
    send(0, 16'h0100, 16'h0200);
    n_checks++; if (ch_ready !== 2'b10) begin n_fail++; $display("FAIL single_pend_ready got %b want 10", ch_ready); end
    n_checks++; if (fir_go !== 1'b0) begin n_fail++; $display("FAIL single_go_early got %b want 0", fir_go); end
    step();
    n_checks++; if (fir_go !== 1'b1) begin n_fail++; $display("FAIL single_go got %b want 1", fir_go); end
    n_checks++; if (fir_x !== 16'h0100) begin n_fail++; $display("FAIL single_fir_x got %h want 0100", fir_x); end
    n_checks++; if (fir_a !== 16'h0200) begin n_fail++; $display("FAIL single_fir_a got %h want 0200", fir_a); end
    n_checks++; if (ch_ready !== 2'b11) begin n_fail++; $display("FAIL single_reload_ready got %b want 11", ch_ready); end
    wait_out(cyc);
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL single_latency got %0d want 6", cyc); end
    n_checks++; if (ch_out_valid !== 2'b01) begin n_fail++; $display("FAIL single_outv got %b want 01", ch_out_valid); end
    n_checks++; if (ch_out_sample !== 16'h1234) begin n_fail++; $display("FAIL single_sample got %h want 1234", ch_out_sample); end
    step();
    n_checks++; if (ch_out_valid !== 2'b00) begin n_fail++; $display("FAIL single_strobe_len got %b want 00", ch_out_valid); end
    n_checks++; if (ch_out_sample !== 16'h1234) begin n_fail++; $display("FAIL single_sample_hold got %h want 1234", ch_out_sample); end
    model_fixed = 1'b0;
  endtask

  task automatic test_pair();
    int ngo, nst;
    int gc[4];
    logic [DW-1:0] gx[4], ss[4];
    logic [NCH-1:0] sv[4];
    ngo = 0;
    nst = 0;
    do_reset();
    model_lat = 1;
    ch_x = {16'h0020, 16'h0010};
    ch_a = {16'h0002, 16'h0001};
    ch_valid = 2'b11;
    step();
    ch_valid = 2'b00;
    for (int c = 0; c < 40; c++) begin
      if (fir_go && ngo < 4) begin gc[ngo] = c; gx[ngo] = fir_x; ngo++; end
      if (ch_out_valid != '0 && nst < 4) begin sv[nst] = ch_out_valid; ss[nst] = ch_out_sample; nst++; end
      step();
    end
    n_checks++; if (ngo !== 2) begin n_fail++; $display("FAIL pair_go_count got %0d want 2", ngo); end
    n_checks++; if (nst !== 2) begin n_fail++; $display("FAIL pair_strobe_count got %0d want 2", nst); end
    if (ngo >= 2) begin
      n_checks++; if (gx[0] !== 16'h0010) begin n_fail++; $display("FAIL pair_first_x got %h want 0010", gx[0]); end
      n_checks++; if (gx[1] !== 16'h0020) begin n_fail++; $display("FAIL pair_second_x got %h want 0020", gx[1]); end
      n_checks++; if (gc[1] - gc[0] !== 3) begin n_fail++; $display("FAIL pair_go_spacing got %0d want 3", gc[1] - gc[0]); end
    end
    if (nst >= 2) begin
      n_checks++; if (sv[0] !== 2'b01 || ss[0] !== 16'h0011) begin n_fail++; $display("FAIL pair_out0 got %b/%h want 01/0011", sv[0], ss[0]); end
      n_checks++; if (sv[1] !== 2'b10 || ss[1] !== 16'h0022) begin n_fail++; $display("FAIL pair_out1 got %b/%h want 10/0022", sv[1], ss[1]); end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [NCH-1:0] ev;
    logic [DW-1:0]  es;
    k = 0;
    do_reset();
    model_lat = 2;
    ch_x = {16'h0B00, 16'h0A00};
    ch_a = {16'h000B, 16'h000A};
    ch_valid = 2'b11;
    for (int c = 0; c < 300 && k < 8; c++) begin
      if (ch_out_valid != '0) begin
        ev = (k % 2 == 0) ? 2'b01 : 2'b10;
        es = (k % 2 == 0) ? 16'h0A0A : 16'h0B0B;
        n_checks++; if (ch_out_valid !== ev) begin n_fail++; $display("FAIL b2b_order[%0d] got %b want %b", k, ch_out_valid, ev); end
        n_checks++; if (ch_out_sample !== es) begin n_fail++; $display("FAIL b2b_sample[%0d] got %h want %h", k, ch_out_sample, es); end
        k++;
      end
      step();
    end
    ch_valid = 2'b00;
    n_checks++; if (k !== 8) begin n_fail++; $display("FAIL b2b_job_count got %0d want 8", k); end
  endtask

  task automatic test_timeout();
    int cnt, cyc;
    bit saw_out;
    saw_out = 1'b0;
    do_reset();
    model_en  = 1'b0;
    model_lat = 2;
    send(0, 16'h0100, 16'h0002);
    step();
    n_checks++; if (fir_go !== 1'b1 || fir_x !== 16'h0100) begin n_fail++; $display("FAIL to_first_go got %b/%h want 1/0100", fir_go, fir_x); end
    ch_x[DW +: DW] = 16'h0300;
    ch_a[DW +: DW] = 16'h0004;
    ch_valid[1] = 1'b1;
    step();
    ch_valid[1] = 1'b0;
    cnt = 1;
    while (!err_timeout && cnt < 1100) begin
      if (ch_out_valid != '0) saw_out = 1'b1;
      step();
      cnt++;
    end
    n_checks++; if (cnt !== 1024) begin n_fail++; $display("FAIL to_cycles got %0d want 1024", cnt); end
    n_checks++; if (saw_out !== 1'b0) begin n_fail++; $display("FAIL to_no_output got %b want 0", saw_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle got %b want 0", busy); end
    model_en = 1'b1;
    step();
    n_checks++; if (fir_go !== 1'b1 || fir_x !== 16'h0300) begin n_fail++; $display("FAIL to_next_grant got %b/%h want 1/0300", fir_go, fir_x); end
    wait_out(cyc);
    n_checks++; if (ch_out_valid !== 2'b10 || ch_out_sample !== 16'h0304) begin n_fail++; $display("FAIL to_next_out got %b/%h want 10/0304", ch_out_valid, ch_out_sample); end
    step();
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b want 1", err_timeout); end
  endtask

  task automatic test_reset_mid_busy();
    bit bad;
    bad = 1'b0;
    model_lat = 10;
    send(0, 16'h0055, 16'h0001);
    step();
    step();
    step();
    step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_checks++; if (fir_go !== 1'b0 || ch_out_valid !== 2'b00) begin n_fail++; $display("FAIL midrst_outs got %b/%b want 0/00", fir_go, ch_out_valid); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %b want 0", err_timeout); end
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (ch_ready !== 2'b11) begin n_fail++; $display("FAIL midrst_ready got %b want 11", ch_ready); end
    for (int c = 0; c < 15; c++) begin
      if (ch_out_valid != '0 || busy || err_timeout) bad = 1'b1;
      step();
    end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL midrst_late_done got %b want 0", bad); end
  endtask

`ifdef FIR_ARB_STATS_EN
  task automatic test_stats();
    int cyc;
    do_reset();
    n_checks++; if (grant_cnt !== 32'h0) begin n_fail++; $display("FAIL stats_reset got %h want 0", grant_cnt); end
    model_en  = 1'b1;
    model_lat = 2;
    for (int j = 0; j < 3; j++) begin
      send(1, 16'h0010, 16'h0001);
      wait_out(cyc);
      step();
    end
    model_en = 1'b0;
    send(1, 16'h0010, 16'h0001);
    cyc = 0;
    while (!err_timeout && cyc < 1200) begin step(); cyc++; end
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL stats_timeout got %b want 1", err_timeout); end
    n_checks++; if (grant_cnt[31:16] !== 16'd3) begin n_fail++; $display("FAIL stats_ch1 got %0d want 3", grant_cnt[31:16]); end
    n_checks++; if (grant_cnt[15:0] !== 16'd0) begin n_fail++; $display("FAIL stats_ch0 got %0d want 0", grant_cnt[15:0]); end
    model_en = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    ch_valid = '0;
    ch_x = '0;
    ch_a = '0;
    test_reset();
    test_single();
    test_pair();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
`ifdef FIR_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
